fft_control_param: RTL and testbench

Parametrised radix-2 FFT sequencer, successor to the fixed 1024-point control block. Supports a runtime-selectable transform size up to 2^LOG2_N_MAX points. Drives ping-pong memory bank selection, butterfly read/write addresses and twiddle addresses, with a latency-matched write pipeline. Adds stall, abort, inter-stage drain and a start/busy/done handshake; sits between the top-level host interface and the butterfly datapath and memories.

---
 rtl/fft_control_param.sv | 175 +++++++++++++++++
 tb/tb_fft_control_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_control_param.sv
// fft_control_param: radix-2 FFT sequencer for runtime sizes up to 2^LOG2_N_MAX points.
// Issues butterfly read/twiddle addresses per stage and replays them BFLY_LAT cycles later as writes.
module fft_control_param #(
    parameter int LOG2_N_MAX = 10,
    parameter int BFLY_LAT   = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [3:0]            i_log2_n,
    input  logic                  i_inverse,
    input  logic                  i_stall,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_inverse,
    output logic [3:0]            o_stage,
    output logic                  o_rd_valid,
    output logic                  o_rd_bank,
    output logic [LOG2_N_MAX-1:0] o_rd_addr_top,
    output logic [LOG2_N_MAX-1:0] o_rd_addr_bot,
    output logic [LOG2_N_MAX-2:0] o_tw_addr,
    output logic                  o_wr_valid,
    output logic                  o_wr_bank,
    output logic [LOG2_N_MAX-1:0] o_wr_addr_top,
    output logic [LOG2_N_MAX-1:0] o_wr_addr_bot,
    output logic                  o_result_bank
);
    localparam int AW = LOG2_N_MAX;
    localparam int PW = AW - 1;
    localparam logic [3:0] LMAX = 4'(LOG2_N_MAX);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state, state_n;
    logic [3:0]    s, s_n, l_reg, l_n;
    logic [PW-1:0] p, p_n;
    logic [2:0]    cnt, cnt_n;
    logic          inv, inv_n, err, err_n, done, done_n;

    logic          run, legal, last_pair, last_stage;
    logic [AW-1:0] pw, half, mask, last_p, top, bot;

    assign run        = state == RUN;
    assign legal      = i_log2_n >= 4'd2 && i_log2_n <= LMAX;
    assign pw         = {1'b0, p};
    assign half       = AW'(1) << s;
    assign mask       = half - AW'(1);
    assign last_p     = (AW'(1) << (l_reg - 4'd1)) - AW'(1);
    assign last_pair  = pw == last_p;
    assign last_stage = s == l_reg - 4'd1;
    assign top        = ((pw >> s) << (s + 4'd1)) | (pw & mask);
    assign bot        = top + half;

    always_comb begin
        state_n = state;
        s_n     = s;
        p_n     = p;
        cnt_n   = cnt;
        l_n     = l_reg;
        inv_n   = inv;
        err_n   = 1'b0;
        done_n  = 1'b0;
        if (i_abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    if (legal) begin
                        state_n = RUN;
                        l_n     = i_log2_n;
                        inv_n   = i_inverse;
                        s_n     = 4'd0;
                        p_n     = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                RUN: if (!i_stall) begin
                    if (last_pair) begin
                        state_n = DRAIN;
                        cnt_n   = 3'(BFLY_LAT);
                    end else begin
                        p_n = p + 1'b1;
                    end
                end
                DRAIN: if (!i_stall) begin
                    cnt_n = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state_n = last_stage ? DONE : RUN;
                        s_n     = last_stage ? s : s + 4'd1;
                        p_n     = '0;
                    end
                end
                default: if (!i_stall) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            s     <= 4'd0;
            p     <= '0;
            cnt   <= 3'd0;
            l_reg <= 4'd0;
            inv   <= 1'b0;
            err   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            s     <= s_n;
            p     <= p_n;
            cnt   <= cnt_n;
            l_reg <= l_n;
            inv   <= inv_n;
            err   <= err_n;
            done  <= done_n;
        end
    end

    // Read-side address/bank values shifted into the write delay line
    logic [AW-1:0]       rd_top, rd_bot;
    logic [BFLY_LAT-1:0] pv, pk;
    logic [AW-1:0]       pt [BFLY_LAT];
    logic [AW-1:0]       pb [BFLY_LAT];

    assign rd_top = run ? top : '0;
    assign rd_bot = run ? bot : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pv <= '0;
            pk <= '0;
            for (int i = 0; i < BFLY_LAT; i++) begin
                pt[i] <= '0;
                pb[i] <= '0;
            end
        end else if (i_abort) begin
            pv <= '0;
        end else if (!i_stall) begin
            pv[0] <= run;
            pk[0] <= ~s[0];
            pt[0] <= rd_top;
            pb[0] <= rd_bot;
            for (int i = 1; i < BFLY_LAT; i++) begin
                pv[i] <= pv[i-1];
                pk[i] <= pk[i-1];
                pt[i] <= pt[i-1];
                pb[i] <= pb[i-1];
            end
        end
    end

    // Twiddle stride always targets the N_MAX table, independent of L
    assign o_tw_addr     = run ? PW'((pw & mask) << (4'(AW - 1) - s)) : '0;
    assign o_rd_addr_top = rd_top;
    assign o_rd_addr_bot = rd_bot;
    assign o_rd_valid    = run & ~i_stall & ~i_abort;
    assign o_rd_bank     = s[0];
    assign o_wr_valid    = pv[BFLY_LAT-1] & ~i_stall & ~i_abort;
    assign o_wr_bank     = pk[BFLY_LAT-1];
    assign o_wr_addr_top = pt[BFLY_LAT-1];
    assign o_wr_addr_bot = pb[BFLY_LAT-1];
    assign o_busy        = state != IDLE;
    assign o_done        = done;
    assign o_err         = err;
    assign o_inverse     = inv;
    assign o_stage       = s;
    assign o_result_bank = l_reg[0];
endmodule

// File: tb/tb_fft_control_param.sv
// tb_fft_control_param: scoreboard bench; stimulus queues expected reads, writes, done and err pulses,
// a negedge monitor pops and compares them against what the sequencer presents.
module tb_fft_control_param;
    localparam int MAX = 10;
    localparam int LAT = 2;
    localparam int BIG = 1 << 30;

    logic clk = 1'b0, rst_n = 1'b0;
    logic i_start = 1'b0, i_inverse = 1'b0, i_stall = 1'b0, i_abort = 1'b0;
    logic [3:0] i_log2_n = 4'd0;
    logic o_busy, o_done, o_err, o_inverse, o_rd_valid, o_rd_bank, o_wr_valid, o_wr_bank, o_result_bank;
    logic [3:0] o_stage;
    logic [MAX-1:0] o_rd_addr_top, o_rd_addr_bot, o_wr_addr_top, o_wr_addr_bot;
    logic [MAX-2:0] o_tw_addr;

    fft_control_param #(.LOG2_N_MAX(MAX), .BFLY_LAT(LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_log2_n(i_log2_n), .i_inverse(i_inverse),
        .i_stall(i_stall), .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_inverse(o_inverse), .o_stage(o_stage), .o_rd_valid(o_rd_valid), .o_rd_bank(o_rd_bank),
        .o_rd_addr_top(o_rd_addr_top), .o_rd_addr_bot(o_rd_addr_bot), .o_tw_addr(o_tw_addr),
        .o_wr_valid(o_wr_valid), .o_wr_bank(o_wr_bank), .o_wr_addr_top(o_wr_addr_top),
        .o_wr_addr_bot(o_wr_addr_bot), .o_result_bank(o_result_bank)
    );

    always #5 clk = ~clk;

    typedef struct {int top; int bot; int tw; int bank; int stage; int uc;} ent_t;
    typedef struct {int cyc; int rb; int inv;} dn_t;

    ent_t rd_q[$], wr_q[$];
    dn_t  done_q[$];
    int   err_q[$];
    int   checks = 0, failures = 0;
    int   uc = 0, cyc = 0;
    bit   arm = 1'b0;
    ent_t re, we;
    dn_t  de;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference order: walk butterfly blocks of size 2*half, pairs inside each block
    task automatic push_xfer(input int l, input int inv, input int lim, input int extra);
        int np, n, p, u, half;
        ent_t e;
        np = 1 << (l - 1);
        n = 1 << l;
        for (int s = 0; s < l; s++) begin
            half = 1 << s;
            p = 0;
            for (int blk = 0; blk < n; blk += 2 * half)
                for (int j = 0; j < half; j++) begin
                    u = s * (np + LAT) + p;
                    e = '{top: blk + j, bot: blk + j + half, tw: j << (MAX - 1 - s), bank: s & 1, stage: s, uc: u};
                    if (u < lim) rd_q.push_back(e);
                    e.bank ^= 1;
                    e.uc = u + LAT;
                    if (e.uc < lim) wr_q.push_back(e);
                    p++;
                end
        end
        if (lim == BIG) done_q.push_back('{cyc: l * (np + LAT) + 1 + extra, rb: l & 1, inv: inv});
    endtask

    task automatic start(input int l, input bit inv, input bit accepted);
        @(posedge clk); #1;
        i_start = 1'b1;
        i_log2_n = 4'(l);
        i_inverse = inv;
        arm = accepted;
        @(posedge clk); #1;
        i_start = 1'b0;
        arm = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && done_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("done_timeout", done_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
        chk("rd_leftover", rd_q.size(), 0);
        chk("wr_leftover", wr_q.size(), 0);
    endtask

    always @(posedge clk) begin
        if (arm) begin
            uc <= 0;
            cyc <= 0;
        end else begin
            cyc <= cyc + 1;
            if (!i_stall) uc <= uc + 1;
        end
    end

    always @(negedge clk) if (rst_n) begin
        if (o_rd_valid) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                re = rd_q.pop_front();
                chk("rd_top", int'(o_rd_addr_top), re.top);
                chk("rd_bot", int'(o_rd_addr_bot), re.bot);
                chk("rd_tw", int'(o_tw_addr), re.tw);
                chk("rd_bank", int'(o_rd_bank), re.bank);
                chk("rd_stage", int'(o_stage), re.stage);
                chk("rd_cycle", uc, re.uc);
            end
        end
        if (o_wr_valid) begin
            if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                we = wr_q.pop_front();
                chk("wr_top", int'(o_wr_addr_top), we.top);
                chk("wr_bot", int'(o_wr_addr_bot), we.bot);
                chk("wr_bank", int'(o_wr_bank), we.bank);
                chk("wr_cycle", uc, we.uc);
            end
        end
        if (o_done) begin
            if (done_q.size() == 0) chk("done_unexpected", 1, 0);
            else begin
                de = done_q.pop_front();
                chk("done_cycle", cyc, de.cyc);
                chk("result_bank", int'(o_result_bank), de.rb);
                chk("done_inverse", int'(o_inverse), de.inv);
                chk("done_busy", int'(o_busy), 0);
            end
        end
        if (o_err) begin
            chk("err_expected", int'(err_q.size() > 0), 1);
            if (err_q.size() > 0) void'(err_q.pop_front());
        end
        if (i_stall) chk("stall_valid", int'({o_rd_valid, o_wr_valid}), 0);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", $countones({o_busy, o_done, o_err, o_inverse, o_stage, o_rd_valid, o_rd_bank,
            o_rd_addr_top, o_rd_addr_bot, o_tw_addr, o_wr_valid, o_wr_bank, o_wr_addr_top, o_wr_addr_bot,
            o_result_bank}), 0);
        rst_n = 1'b1;

        push_xfer(3, 0, BIG, 0);
        start(3, 1'b0, 1'b1);
        chk("busy_after_start", int'(o_busy), 1);
        wait_done(100);

        push_xfer(10, 1, BIG, 0);
        start(10, 1'b1, 1'b1);
        wait_done(6000);

        push_xfer(3, 0, BIG, 4);
        start(3, 1'b0, 1'b1);
        repeat (7) @(posedge clk);
        #1 i_stall = 1'b1;
        repeat (4) @(posedge clk);
        #1 i_stall = 1'b0;
        wait_done(100);

        push_xfer(3, 0, 8, 0);
        start(3, 1'b0, 1'b1);
        repeat (8) @(posedge clk);
        #1 i_abort = 1'b1;
        @(posedge clk);
        #1 i_abort = 1'b0;
        chk("abort_busy", int'(o_busy), 0);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_rd_left", rd_q.size(), 0);
        chk("abort_wr_left", wr_q.size(), 0);
        push_xfer(3, 1, BIG, 0);
        start(3, 1'b1, 1'b1);
        wait_done(100);

        err_q.push_back(1);
        start(1, 1'b0, 1'b0);
        chk("err1_busy", int'(o_busy), 0);
        err_q.push_back(11);
        start(11, 1'b0, 1'b0);
        chk("err11_busy", int'(o_busy), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("err_pending", err_q.size(), 0);
        chk("err_idle_busy", int'(o_busy), 0);

        push_xfer(4, 0, BIG, 0);
        start(4, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1 i_start = 1'b1;
        i_log2_n = 4'd2;
        @(posedge clk);
        #1 i_start = 1'b0;
        chk("busy_start_stage", int'(o_stage), 0);
        chk("busy_start_busy", int'(o_busy), 1);
        wait_done(100);

        push_xfer(5, 0, BIG, 0);
        start(5, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", $countones({o_busy, o_done, o_err, o_inverse, o_stage, o_rd_valid,
            o_rd_bank, o_rd_addr_top, o_rd_addr_bot, o_tw_addr, o_wr_valid, o_wr_bank, o_wr_addr_top,
            o_wr_addr_bot, o_result_bank}), 0);
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post_reset_busy", int'(o_busy), 0);
        push_xfer(3, 1, BIG, 0);
        start(3, 1'b1, 1'b1);
        wait_done(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
